speed_divisor_ctrl: RTL and testbench
=====================================

// Module: speed_divisor_ctrl
// PURPOSE
//  Upstream control stage for the 32-bit clock divider. Converts three raw push-buttons into the
//  div_clk_count word the divider consumes: faster / slower / back-to-default, with saturation.
//  Divider output frequency is inclk/(2*div_clk_count), so a smaller count means a faster clock.
//  Optionally slews the count gradually so the divided clock never jumps in frequency.
// PARAMETERS
//  DEFAULT_COUNT  32'd25_000   count loaded at reset and on btn_default
//  MIN_COUNT      32'd2_500    lower clamp (fastest divided clock)
//  MAX_COUNT      32'd250_000  upper clamp (slowest divided clock)
//  STEP           32'd2_500    change applied per accepted faster/slower press
//  DEB_CYCLES     20'd500_000  cycles a synchronised button must hold a level before it is accepted
//  RAMP_CYCLES    16'd5_000    cycles between slew steps (used only with DIV_RAMP_EN)
//  RAMP_STEP      32'd250      maximum count change per slew step (used only with DIV_RAMP_EN)
// PORTS
//  inclk          in   1   system clock; single clock domain
//  Reset          in   1   asynchronous, active-low reset
//  btn_faster     in   1   raw button, active-high, asynchronous to inclk
//  btn_slower     in   1   raw button, active-high, asynchronous to inclk
//  btn_default    in   1   raw button, active-high, asynchronous to inclk
//  div_clk_count  out  32  count word driven to the divider
//  at_min         out  1   1 when target == MIN_COUNT
//  at_max         out  1   1 when target == MAX_COUNT
//  busy           out  1   1 while div_clk_count != target
// BEHAVIOUR
//  Reset (Reset=0, async): target = div_clk_count = DEFAULT_COUNT; busy = 0; at_min and at_max
//    reflect DEFAULT_COUNT; all sync, debounce and ramp counters = 0; debounced levels = 0.
//  Input path per button: 2-FF synchroniser, then debounce. The debounced level changes only after
//    the synchronised input has differed from it for DEB_CYCLES consecutive cycles. Any bounce
//    restarts the count.
//  Command: one-cycle pulse on the rising edge of the debounced level. Release generates nothing.
//    Holding a button gives exactly one command.
//  Priority in a single cycle: default > (faster XOR slower). Faster and slower together with no
//    default: both ignored, target unchanged.
//  Faster: target = max(target - STEP, MIN_COUNT). Compute at 33 bits; no unsigned wrap below 0.
//  Slower: target = min(target + STEP, MAX_COUNT). Compute at 33 bits; no wrap past 2^32-1.
//  Default: target = DEFAULT_COUNT.
//  Latency: button edge -> target update = 2 (sync) + DEB_CYCLES + 1 cycles.
//  Flags: at_min, at_max and busy are registered and valid the cycle after target or count changes.
//  div_clk_count is registered and glitch-free. The divider samples it every cycle.
//  Reset mid-ramp or mid-debounce: abandon all in-flight state immediately; outputs return to reset
//    values.
// CONFIGURATION
//  DIV_RAMP_EN defined: a ramp counter counts 0..RAMP_CYCLES-1 while busy. At each wrap,
//    div_clk_count moves toward target by min(|target - count|, RAMP_STEP).
//  DIV_RAMP_EN defined, target changes mid-ramp: slew continues from the current count toward the
//    new target; the ramp counter is not restarted.
//  DIV_RAMP_EN undefined: div_clk_count = target, registered one cycle after the target update.
//    busy is high for that one cycle only. No ramp counter or RAMP_* logic is synthesised.
// STRUCTURE
//  Package speed_ctrl_pkg: CNT_W = 32, DEB_W = 20, RAMP_W = 16, default MIN/MAX/STEP constants,
//    typedef cmd_t {CMD_NONE, CMD_FASTER, CMD_SLOWER, CMD_DEFAULT}.
//  Sub-module btn_debounce (sync + debounce + rise pulse), instantiated 3x.
//  Top level holds: command arbitration, saturating target arithmetic, ramp/output register, flags.
// TESTING (sim params: DEFAULT=100, MIN=20, MAX=200, STEP=30, DEB_CYCLES=4, RAMP_CYCLES=3, RAMP_STEP=10)
//  Reset release -> div_clk_count=100, busy=0, at_min=at_max=0.
//  Clean btn_slower press held 20 cycles -> a single update: target 130, count reaches 130; no
//    second step while held.
//  btn_faster bouncing 1-0-1 at 2-cycle intervals, then stable -> exactly one decrement, 100 -> 70,
//    and only after 4 stable cycles.
//  Four btn_slower presses from 100 -> 130, 160, 190, 200 (clamped); at_max=1; fifth press: no change.
//  btn_faster + btn_slower same cycle -> no change; btn_default + btn_faster together -> 100.
//  DIV_RAMP_EN: 100 -> 130 emits 110, 120, 130 at 3-cycle spacing with busy=1 until equal.
//    Assert Reset mid-ramp -> count=100 asynchronously.

Source files
------------

// File: rtl/speed_ctrl_pkg.sv
// Shared widths, default limits and command encoding for the speed divisor control path.
package speed_ctrl_pkg;

    localparam int CNT_W  = 32;
    localparam int DEB_W  = 20;
    localparam int RAMP_W = 16;

    localparam logic [CNT_W-1:0] DEF_DEFAULT_COUNT = 32'd25_000;
    localparam logic [CNT_W-1:0] DEF_MIN_COUNT     = 32'd2_500;
    localparam logic [CNT_W-1:0] DEF_MAX_COUNT     = 32'd250_000;
    localparam logic [CNT_W-1:0] DEF_STEP          = 32'd2_500;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_FASTER,
        CMD_SLOWER,
        CMD_DEFAULT
    } cmd_t;

    // Default wins; faster and slower pressed together cancel out.
    function automatic cmd_t arbitrate(input logic faster, input logic slower, input logic dflt);
        if (dflt)
            return CMD_DEFAULT;
        else if (faster && !slower)
            return CMD_FASTER;
        else if (slower && !faster)
            return CMD_SLOWER;
        else
            return CMD_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button to one-cycle press pulse: 2-FF synchroniser, hold-time debounce, rising-edge detect.
module btn_debounce
    import speed_ctrl_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEB_CYCLES = 20'd500_000
) (
    input  logic inclk,
    input  logic Reset,
    input  logic btn,
    output logic rise
);

    logic             sync_p0;
    logic             sync_p1;
    logic             level;
    logic [DEB_W-1:0] deb_cnt;

    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            deb_cnt <= '0;
            rise    <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            // Any cycle where the synchronised input agrees with the level restarts the hold count.
            if (sync_p1 == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_CYCLES - DEB_W'(1)) begin
                deb_cnt <= '0;
                level   <= sync_p1;
                rise    <= sync_p1;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/speed_divisor_ctrl.sv
// Button-driven divisor word for the clock divider with saturating faster/slower/default control.
// Optional gradual slew of the output count is enabled by defining DIV_RAMP_EN.
module speed_divisor_ctrl
    import speed_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEFAULT_COUNT = DEF_DEFAULT_COUNT,
    parameter logic [CNT_W-1:0] MIN_COUNT     = DEF_MIN_COUNT,
    parameter logic [CNT_W-1:0] MAX_COUNT     = DEF_MAX_COUNT,
    parameter logic [CNT_W-1:0] STEP          = DEF_STEP,
    parameter logic [DEB_W-1:0] DEB_CYCLES    = 20'd500_000
`ifdef DIV_RAMP_EN
    ,
    parameter logic [RAMP_W-1:0] RAMP_CYCLES  = 16'd5_000,
    parameter logic [CNT_W-1:0]  RAMP_STEP    = 32'd250
`endif
) (
    input  logic             inclk,
    input  logic             Reset,
    input  logic             btn_faster,
    input  logic             btn_slower,
    input  logic             btn_default,
    output logic [CNT_W-1:0] div_clk_count,
    output logic             at_min,
    output logic             at_max,
    output logic             busy
);

    logic             rise_faster;
    logic             rise_slower;
    logic             rise_default;
    cmd_t             cmd;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] next_target;

    // Arithmetic is carried at 33 bits so neither direction can wrap before clamping.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] cur);
        logic [CNT_W:0] diff;
        diff = {1'b0, cur} - {1'b0, STEP};
        if (diff[CNT_W] || (diff[CNT_W-1:0] < MIN_COUNT))
            return MIN_COUNT;
        return diff[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cur);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + {1'b0, STEP};
        if (sum > {1'b0, MAX_COUNT})
            return MAX_COUNT;
        return sum[CNT_W-1:0];
    endfunction

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_faster (
        .inclk(inclk), .Reset(Reset), .btn(btn_faster), .rise(rise_faster)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_slower (
        .inclk(inclk), .Reset(Reset), .btn(btn_slower), .rise(rise_slower)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_default (
        .inclk(inclk), .Reset(Reset), .btn(btn_default), .rise(rise_default)
    );

    always_comb begin
        cmd         = arbitrate(rise_faster, rise_slower, rise_default);
        next_target = target;
        unique case (cmd)
            CMD_FASTER:  next_target = sat_dec(target);
            CMD_SLOWER:  next_target = sat_inc(target);
            CMD_DEFAULT: next_target = DEFAULT_COUNT;
            default:     next_target = target;
        endcase
    end

    // Target stage: flags follow the target one cycle later.
    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset) begin
            target <= DEFAULT_COUNT;
            at_min <= (DEFAULT_COUNT == MIN_COUNT);
            at_max <= (DEFAULT_COUNT == MAX_COUNT);
            busy   <= 1'b0;
        end else begin
            target <= next_target;
            at_min <= (target == MIN_COUNT);
            at_max <= (target == MAX_COUNT);
            busy   <= (div_clk_count != target);
        end
    end

`ifdef DIV_RAMP_EN
    logic [RAMP_W-1:0] ramp_cnt;

    function automatic logic [CNT_W-1:0] slew(input logic [CNT_W-1:0] cur,
                                              input logic [CNT_W-1:0] tgt);
        logic signed [CNT_W:0] delta;
        logic signed [CNT_W:0] lim;
        delta = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        lim   = $signed({1'b0, RAMP_STEP});
        if (delta > lim)
            return cur + RAMP_STEP;
        else if (delta < -lim)
            return cur - RAMP_STEP;
        return tgt;
    endfunction

    // Output stage: one bounded step per ramp-counter wrap; a moving target does not restart the counter.
    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset) begin
            ramp_cnt      <= '0;
            div_clk_count <= DEFAULT_COUNT;
        end else if (div_clk_count != target) begin
            if (ramp_cnt == RAMP_CYCLES - RAMP_W'(1)) begin
                ramp_cnt      <= '0;
                div_clk_count <= slew(div_clk_count, target);
            end else begin
                ramp_cnt <= ramp_cnt + RAMP_W'(1);
            end
        end else begin
            ramp_cnt <= '0;
        end
    end
`else
    // Output stage: count follows target one cycle later.
    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset)
            div_clk_count <= DEFAULT_COUNT;
        else
            div_clk_count <= target;
    end
`endif

endmodule

// File: tb/tb_speed_divisor_ctrl.sv
// Directed bench for speed_divisor_ctrl with small simulation parameters; honours DIV_RAMP_EN.
module tb_speed_divisor_ctrl;

    logic        inclk;
    logic        Reset;
    logic        btn_faster;
    logic        btn_slower;
    logic        btn_default;
    logic [31:0] div_clk_count;
    logic        at_min;
    logic        at_max;
    logic        busy;

    int checks;
    int errors;

    speed_divisor_ctrl #(
        .DEFAULT_COUNT(32'd100),
        .MIN_COUNT    (32'd20),
        .MAX_COUNT    (32'd200),
        .STEP         (32'd30),
        .DEB_CYCLES   (20'd4)
`ifdef DIV_RAMP_EN
        ,
        .RAMP_CYCLES  (16'd3),
        .RAMP_STEP    (32'd10)
`endif
    ) dut (
        .inclk        (inclk),
        .Reset        (Reset),
        .btn_faster   (btn_faster),
        .btn_slower   (btn_slower),
        .btn_default  (btn_default),
        .div_clk_count(div_clk_count),
        .at_min       (at_min),
        .at_max       (at_max),
        .busy         (busy)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge inclk);
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // mask bits: [0] faster, [1] slower, [2] default
    task automatic press(input logic [2:0] mask);
        btn_faster  = mask[0];
        btn_slower  = mask[1];
        btn_default = mask[2];
        tick(12);
        btn_faster  = 1'b0;
        btn_slower  = 1'b0;
        btn_default = 1'b0;
        tick(40);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        Reset       = 1'b0;
        btn_faster  = 1'b0;
        btn_slower  = 1'b0;
        btn_default = 1'b0;

        tick(3);
        check_cnt("reset_count", div_clk_count, 32'd100);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_at_min", at_min, 1'b0);
        check_bit("reset_at_max", at_max, 1'b0);
        Reset = 1'b1;
        tick(2);
        check_cnt("post_reset_count", div_clk_count, 32'd100);
        check_bit("post_reset_busy", busy, 1'b0);

        // Clean slower press held for 20 cycles
        btn_slower = 1'b1;
        tick(5);
        check_cnt("slower_not_yet", div_clk_count, 32'd100);
`ifndef DIV_RAMP_EN
        tick(2);
        check_cnt("slower_latency_7", div_clk_count, 32'd100);
        check_bit("slower_busy_7", busy, 1'b0);
        tick(1);
        check_cnt("slower_latency_8", div_clk_count, 32'd130);
        check_bit("slower_busy_8", busy, 1'b1);
        tick(1);
        check_bit("slower_busy_9", busy, 1'b0);
        tick(11);
`else
        tick(15);
`endif
        check_cnt("slower_held_20", div_clk_count, 32'd130);
        btn_slower = 1'b0;
        tick(40);
        check_cnt("slower_after_release", div_clk_count, 32'd130);
        check_bit("slower_idle_busy", busy, 1'b0);

        press(3'b100);
        check_cnt("default_from_130", div_clk_count, 32'd100);

        // Bouncing faster: 1-0-1 at 2-cycle intervals, then stable high
        btn_faster = 1'b1;
        tick(2);
        btn_faster = 1'b0;
        tick(2);
        btn_faster = 1'b1;
        tick(5);
        check_cnt("bounce_not_yet", div_clk_count, 32'd100);
`ifndef DIV_RAMP_EN
        tick(2);
        check_cnt("bounce_latency_7", div_clk_count, 32'd100);
        tick(1);
        check_cnt("bounce_latency_8", div_clk_count, 32'd70);
        tick(4);
`else
        tick(7);
`endif
        btn_faster = 1'b0;
        tick(40);
        check_cnt("bounce_single_dec", div_clk_count, 32'd70);

        press(3'b100);
        check_cnt("default_from_70", div_clk_count, 32'd100);

        // Slower up to the upper clamp
        press(3'b010);
        check_cnt("up_130", div_clk_count, 32'd130);
        press(3'b010);
        check_cnt("up_160", div_clk_count, 32'd160);
        press(3'b010);
        check_cnt("up_190", div_clk_count, 32'd190);
        check_bit("at_max_190", at_max, 1'b0);
        press(3'b010);
        check_cnt("up_200_clamp", div_clk_count, 32'd200);
        check_bit("at_max_200", at_max, 1'b1);
        press(3'b010);
        check_cnt("up_fifth_hold", div_clk_count, 32'd200);
        check_bit("at_max_fifth", at_max, 1'b1);

        press(3'b011);
        check_cnt("faster_and_slower", div_clk_count, 32'd200);
        press(3'b101);
        check_cnt("default_and_faster", div_clk_count, 32'd100);
        check_bit("at_max_cleared", at_max, 1'b0);

        // Faster down to the lower clamp
        press(3'b001);
        check_cnt("down_70", div_clk_count, 32'd70);
        press(3'b001);
        check_cnt("down_40", div_clk_count, 32'd40);
        check_bit("at_min_40", at_min, 1'b0);
        press(3'b001);
        check_cnt("down_20_clamp", div_clk_count, 32'd20);
        check_bit("at_min_20", at_min, 1'b1);
        press(3'b001);
        check_cnt("down_fourth_hold", div_clk_count, 32'd20);
        press(3'b100);
        check_cnt("default_from_20", div_clk_count, 32'd100);
        check_bit("at_min_cleared", at_min, 1'b0);

`ifdef DIV_RAMP_EN
        // Slew 100 -> 130 in steps of 10 every 3 cycles
        btn_slower = 1'b1;
        tick(10);
        check_cnt("ramp_110", div_clk_count, 32'd110);
        check_bit("ramp_busy_110", busy, 1'b1);
        tick(3);
        check_cnt("ramp_120", div_clk_count, 32'd120);
        tick(3);
        check_cnt("ramp_130", div_clk_count, 32'd130);
        check_bit("ramp_busy_130", busy, 1'b1);
        tick(1);
        check_bit("ramp_busy_done", busy, 1'b0);
        btn_slower = 1'b0;
        tick(40);

        // Reset in the middle of a 130 -> 160 slew
        btn_slower = 1'b1;
        tick(10);
        check_cnt("ramp_mid_140", div_clk_count, 32'd140);
        Reset = 1'b0;
        #1;
        check_cnt("ramp_reset_async", div_clk_count, 32'd100);
        check_bit("ramp_reset_busy", busy, 1'b0);
        btn_slower = 1'b0;
        tick(2);
        Reset = 1'b1;
        tick(40);
        check_cnt("ramp_reset_settled", div_clk_count, 32'd100);
`endif

        // Reset while a press is still being debounced
        press(3'b010);
        check_cnt("pre_reset_130", div_clk_count, 32'd130);
        btn_slower = 1'b1;
        tick(4);
        Reset = 1'b0;
        #1;
        check_cnt("mid_deb_reset_async", div_clk_count, 32'd100);
        check_bit("mid_deb_reset_busy", busy, 1'b0);
        btn_slower = 1'b0;
        tick(2);
        Reset = 1'b1;
        tick(40);
        check_cnt("mid_deb_abandoned", div_clk_count, 32'd100);
        check_bit("mid_deb_idle_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
